// File: rtl/vga_pll_ctrl.sv
// VGA pixel-clock PLL sequencer: pulses the PLL reset, waits for lock with a
// timeout and bounded retries, qualifies lock as stable, then releases the
// downstream video reset. Re-sequences on lock loss or software request.
module vga_pll_ctrl #(
  parameter int unsigned PWRUP_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int unsigned MAX_AB  = (PWRUP_CYCLES > LOCK_TIMEOUT) ? PWRUP_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD  = (LOCK_STABLE > MAX_RETRIES) ? LOCK_STABLE : MAX_RETRIES;
  localparam int unsigned MAX_PAR = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(MAX_PAR) + 1;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_m;
  logic          lock_s;

  // Moore output decode {pll_rst, sys_rst, ready, fail}; applied to the state
  // being entered so the output flops always match the state register.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      RESET_PLL: decode = 4'b1100;
      WAIT_LOCK: decode = 4'b0100;
      STABILIZE: decode = 4'b0100;
      RUN:       decode = 4'b0010;
      FAIL:      decode = 4'b1101;
      default:   decode = 4'b1100;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  // Sequencer: state, per-state cycle counter, status counters and outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
      {pll_rst, sys_rst, ready, fail} <= decode(RESET_PLL);
    end else begin
      cnt <= cnt + CW'(1);
      case (state)
        RESET_PLL: begin
          if (cnt == CW'(PWRUP_CYCLES - 1)) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            {pll_rst, sys_rst, ready, fail} <= decode(WAIT_LOCK);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABILIZE;
            cnt   <= '0;
            {pll_rst, sys_rst, ready, fail} <= decode(STABILIZE);
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_cnt <= retry_cnt + 4'd1;
            cnt       <= '0;
            if (4'(retry_cnt + 4'd1) == 4'(MAX_RETRIES)) begin
              state <= FAIL;
              {pll_rst, sys_rst, ready, fail} <= decode(FAIL);
            end else begin
              state <= RESET_PLL;
              {pll_rst, sys_rst, ready, fail} <= decode(RESET_PLL);
            end
          end
        end
        STABILIZE: begin
          // A lock dropout restarts the timeout window without costing a retry.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            {pll_rst, sys_rst, ready, fail} <= decode(WAIT_LOCK);
          end else if (cnt == CW'(LOCK_STABLE - 1)) begin
            state     <= RUN;
            cnt       <= '0;
            retry_cnt <= '0;
            {pll_rst, sys_rst, ready, fail} <= decode(RUN);
          end
        end
        RUN: begin
          cnt <= '0;
          if (!lock_s || relock_req) begin
            state <= RESET_PLL;
            {pll_rst, sys_rst, ready, fail} <= decode(RESET_PLL);
          end
          if (!lock_s && (lost_cnt != 8'hFF)) begin
            lost_cnt <= lost_cnt + 8'd1;
          end
        end
        FAIL: begin
          cnt <= '0;
          if (relock_req) begin
            state     <= RESET_PLL;
            retry_cnt <= '0;
            {pll_rst, sys_rst, ready, fail} <= decode(RESET_PLL);
          end
        end
        default: begin
          state <= RESET_PLL;
          cnt   <= '0;
          {pll_rst, sys_rst, ready, fail} <= decode(RESET_PLL);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pll_ctrl.sv
// Directed, scoreboard-checked bench for the VGA PLL sequencer.
module tb_vga_pll_ctrl;

  localparam int unsigned PWRUP_CYCLES = 4;
  localparam int unsigned LOCK_TIMEOUT = 16;
  localparam int unsigned LOCK_STABLE  = 8;
  localparam int unsigned MAX_RETRIES  = 3;
  localparam int          LIM          = 300;
  // pll_locked drive edge to ready: 2 sync edges + WAIT_LOCK exit + stable window
  localparam int          READY_LAT    = 2 + 1 + LOCK_STABLE;
  localparam int          LOSS_LAT     = 3;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   ready_seen;
  int   n;
  int   lost_model;

  vga_pll_ctrl #(
    .PWRUP_CYCLES(PWRUP_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRIES (MAX_RETRIES)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lost_cnt  (lost_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0d expected an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge refclk);
      #1;
      ready_seen |= ready;
    end
  endtask

  task automatic measure_prst_high(output int len);
    len = 0;
    while (pll_rst === 1'b1 && len < LIM) begin
      len++;
      tick();
    end
  endtask

  task automatic measure_prst_low(output int len);
    len = 0;
    while (pll_rst === 1'b0 && len < LIM) begin
      len++;
      tick();
    end
  endtask

  task automatic wait_ready(output int len);
    len = 0;
    while (ready !== 1'b1 && len < LIM) begin
      tick();
      len++;
    end
  endtask

  task automatic wait_sysrst(output int len);
    len = 0;
    while (sys_rst !== 1'b1 && len < LIM) begin
      tick();
      len++;
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({pll_rst, sys_rst, ready, fail});
  endfunction

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    ready_seen = 1'b0;

    // reset state
    push("rst_outs", 32'hC);
    push("rst_retry", 0);
    push("rst_lost", 0);
    tick(3);
    check(outs());
    check(32'(retry_cnt));
    check(32'(lost_cnt));

    // nominal start
    rst = 1'b0;
    push("t1_prst_len", PWRUP_CYCLES);
    measure_prst_high(n);
    check(32'(n));
    tick(5);
    pll_locked = 1'b1;
    push("t1_ready_lat", READY_LAT);
    push("t1_sys_rst", 0);
    push("t1_retry", 0);
    wait_ready(n);
    check(32'(n));
    check(32'(sys_rst));
    check(32'(retry_cnt));

    // timeout retries into FAIL
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    push("t2_prst_first", PWRUP_CYCLES);
    measure_prst_high(n);
    check(32'(n));
    for (int i = 0; i < int'(MAX_RETRIES); i++) begin
      push("t2_window", LOCK_TIMEOUT);
      measure_prst_low(n);
      check(32'(n));
      if (i < int'(MAX_RETRIES) - 1) begin
        push("t2_retry_step", 32'(i + 1));
        check(32'(retry_cnt));
        push("t2_prst_repulse", PWRUP_CYCLES);
        measure_prst_high(n);
        check(32'(n));
      end else begin
        push("t2_fail_outs", 32'hD);
        push("t2_fail_retry", MAX_RETRIES);
        check(outs());
        check(32'(retry_cnt));
      end
    end
    tick(10);
    push("t2_fail_hold", 32'hD);
    check(outs());
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    push("t2_relock_retry", 0);
    push("t2_relock_fail", 0);
    push("t2_relock_prst", PWRUP_CYCLES);
    check(32'(retry_cnt));
    check(32'(fail));
    measure_prst_high(n);
    check(32'(n));

    // glitchy lock, with one timeout already recorded
    push("t3_window", LOCK_TIMEOUT);
    measure_prst_low(n);
    check(32'(n));
    push("t3_retry_before", 1);
    check(32'(retry_cnt));
    push("t3_prst", PWRUP_CYCLES);
    measure_prst_high(n);
    check(32'(n));
    pll_locked = 1'b1;
    tick(3 + 5);
    pll_locked = 1'b0;
    ready_seen = 1'b0;
    tick(2);
    pll_locked = 1'b1;
    tick();
    push("t3_no_ready", 0);
    push("t3_retry_kept", 1);
    push("t3_ready_lat", READY_LAT);
    push("t3_retry_clear", 0);
    check(32'(ready_seen));
    check(32'(retry_cnt));
    wait_ready(n);
    check(32'(n + 1));
    check(32'(retry_cnt));

    // lock loss in RUN
    pll_locked = 1'b0;
    push("t4_loss_lat", LOSS_LAT);
    push("t4_ready_low", 0);
    push("t4_lost_one", 1);
    push("t4_rerun", 1);
    wait_sysrst(n);
    check(32'(n));
    check(32'(ready));
    check(32'(lost_cnt));
    pll_locked = 1'b1;
    wait_ready(n);
    check(32'(ready));

    // lock loss and relock_req together: one entry, counted as a loss
    pll_locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    push("t5_both_sysrst", 1);
    push("t5_both_lost", 2);
    push("t5_both_prst", PWRUP_CYCLES);
    push("t5_both_rerun", 1);
    check(32'(sys_rst));
    check(32'(lost_cnt));
    measure_prst_high(n);
    check(32'(n));
    pll_locked = 1'b1;
    wait_ready(n);
    check(32'(ready));

    // relock_req alone leaves lost_cnt alone
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    push("t5_req_sysrst", 1);
    push("t5_req_lost", 2);
    push("t5_req_prst", PWRUP_CYCLES);
    push("t5_req_rerun", 1);
    check(32'(sys_rst));
    check(32'(lost_cnt));
    measure_prst_high(n);
    check(32'(n));
    wait_ready(n);
    check(32'(ready));

    // repeated losses saturate lost_cnt
    lost_model = 2;
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      lost_model = (lost_model < 255) ? lost_model + 1 : 255;
      push("t4_lost_sat", 32'(lost_model));
      wait_sysrst(n);
      pll_locked = 1'b1;
      wait_ready(n);
      check(32'(lost_cnt));
    end

    // reset while in STABILIZE
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tick(6);
    rst = 1'b1;
    tick();
    push("t6_stab_outs", 32'hC);
    push("t6_stab_retry", 0);
    push("t6_stab_lost", 0);
    check(outs());
    check(32'(retry_cnt));
    check(32'(lost_cnt));
    rst = 1'b0;
    push("t6_stab_prst", PWRUP_CYCLES);
    push("t6_stab_ready", 1);
    measure_prst_high(n);
    check(32'(n));
    wait_ready(n);
    check(32'(ready));

    // reset while in RUN
    rst = 1'b1;
    tick();
    push("t6_run_outs", 32'hC);
    push("t6_run_retry", 0);
    push("t6_run_lost", 0);
    check(outs());
    check(32'(retry_cnt));
    check(32'(lost_cnt));
    rst = 1'b0;
    push("t6_run_prst", PWRUP_CYCLES);
    push("t6_run_ready", 1);
    measure_prst_high(n);
    check(32'(n));
    wait_ready(n);
    check(32'(ready));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
